// File: rtl/pool_window_feeder_if.sv
// pool_window_feeder_if: start/busy/done handshake, SRAM read/write and pooling-unit bus
// Ports: start, busy, done            - run request and status
//        rd_en, rd_addr, rd_data      - feature-map SRAM read side
//        pool_en, pool_data, pool_result - pooling unit en/Data_in/Data_out
//        wr_en, wr_addr, wr_data      - result SRAM write side
// master is the feeder; slave is the surroundings (SRAMs, pooling unit, controller).
interface pool_window_feeder_if #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 8
);
  logic start, busy, done, rd_en, pool_en, wr_en;
  logic [ADDR_BITS-1:0] rd_addr, wr_addr;
  logic [DATA_BITS-1:0] rd_data, pool_data, pool_result, wr_data;
  modport master (
    input  start, rd_data, pool_result,
    output busy, done, rd_en, rd_addr, pool_en, pool_data, wr_en, wr_addr, wr_data
  );
  modport slave (
    output start, rd_data, pool_result,
    input  busy, done, rd_en, rd_addr, pool_en, pool_data, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/pool_window_feeder.sv
// pool_window_feeder: walks a feature map window by window, streams pixels into the
// max-pooling unit and writes one pooled result per window.
// Ports: clk, rst (async, active-low), bus (pool_window_feeder_if.master).
module pool_window_feeder #(
  parameter int DATA_BITS = 8,
  parameter int IMG_W     = 4,
  parameter int IMG_H     = 4,
  parameter int POOL      = 2,
  parameter int ADDR_BITS = 8
) (
  input logic clk,
  input logic rst,
  pool_window_feeder_if.master bus
);
  localparam logic [ADDR_BITS-1:0] P_A = ADDR_BITS'(POOL);
  localparam logic [ADDR_BITS-1:0] W_A = ADDR_BITS'(IMG_W);
  localparam logic [ADDR_BITS-1:0] OW  = ADDR_BITS'(IMG_W / POOL);
  localparam logic [ADDR_BITS-1:0] OH  = ADDR_BITS'(IMG_H / POOL);
  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, FINISH} state_t;
  state_t state;
  logic [ADDR_BITS-1:0] win_r, win_c, i, j, nxt_r, nxt_c, nxt_i, nxt_j;
  logic last_px, last_win, wrap_c;
  function automatic logic [ADDR_BITS-1:0] px_addr(input logic [ADDR_BITS-1:0] r, c, y, x);
    return (r * P_A + y) * W_A + c * P_A + x;
  endfunction
  always_comb begin
    last_px  = i == P_A - 1'b1 && j == P_A - 1'b1;
    wrap_c   = win_c == OW - 1'b1;
    last_win = wrap_c && win_r == OH - 1'b1;
    nxt_j    = j == P_A - 1'b1 ? '0 : j + 1'b1;
    nxt_i    = j == P_A - 1'b1 ? i + 1'b1 : i;
    nxt_c    = wrap_c ? '0 : win_c + 1'b1;
    nxt_r    = wrap_c ? win_r + 1'b1 : win_r;
  end
  assign bus.pool_data = bus.rd_data;
  // The pooling unit's output is only final one cycle after its last en, i.e. in WRITE.
  assign bus.wr_data = bus.wr_en ? bus.pool_result : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      win_r       <= '0;
      win_c       <= '0;
      i           <= '0;
      j           <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.rd_en   <= 1'b0;
      bus.pool_en <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.rd_addr <= '0;
      bus.wr_addr <= '0;
    end else begin
      // Read data arrives one cycle after rd_en, so en follows rd_en by one cycle.
      bus.pool_en <= bus.rd_en;
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          win_r    <= '0;
          win_c    <= '0;
          i        <= '0;
          j        <= '0;
          if (bus.start) begin
            state       <= READ;
            bus.busy    <= 1'b1;
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= '0;
          end
        end
        READ: begin
          if (last_px) begin
            state     <= DRAIN;
            bus.rd_en <= 1'b0;
            i         <= '0;
            j         <= '0;
          end else begin
            i           <= nxt_i;
            j           <= nxt_j;
            bus.rd_addr <= px_addr(win_r, win_c, nxt_i, nxt_j);
          end
        end
        DRAIN: begin
          state       <= WRITE;
          bus.wr_en   <= 1'b1;
          bus.wr_addr <= win_r * OW + win_c;
        end
        WRITE: begin
          // pool_en is low here, which clears the unit's running maximum for the next window.
          bus.wr_en <= 1'b0;
          if (last_win) begin
            state    <= FINISH;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            state       <= READ;
            win_r       <= nxt_r;
            win_c       <= nxt_c;
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= px_addr(nxt_r, nxt_c, '0, '0);
          end
        end
        FINISH: begin
          state    <= IDLE;
          bus.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pool_window_feeder.sv
// tb_pool_window_feeder: randomized self-checking bench with SRAM, pooling-unit and window-max reference model
module tb_pool_window_feeder;
  localparam int DB = 8, W = 4, H = 4, P = 2, AB = 8;
  localparam int OW = W / P, N = (H / P) * OW, K = P * P + 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0, miscompares = 0;
  logic [DB-1:0] mem [256];
  int exp_max [N];
  logic [DB-1:0] pres;
  pool_window_feeder_if #(.DATA_BITS(DB), .ADDR_BITS(AB)) bus();
  pool_window_feeder #(.DATA_BITS(DB), .IMG_W(W), .IMG_H(H), .POOL(P), .ADDR_BITS(AB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  // Pooling unit: running maximum while en is high, cleared while en is low.
  always @(posedge clk or negedge rst)
    if (!rst) pres <= '0;
    else pres <= bus.pool_en ? (bus.pool_data > pres ? bus.pool_data : pres) : '0;
  assign bus.pool_result = pres;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic load(input int mode);
    for (int a = 0; a < 256; a++) mem[a] = '0;
    for (int a = 0; a < W * H; a++)
      mem[a] = mode == 0 ? DB'(a) : mode == 1 ? DB'(W * H - 1 - a) : mode == 3 ? DB'($urandom) : '0;
    if (mode == 2) begin
      mem[W + 1] = 8'd200;
      mem[2]     = 8'd255;
    end
    for (int k = 0; k < N; k++) begin
      exp_max[k] = 0;
      for (int y = 0; y < P; y++)
        for (int x = 0; x < P; x++)
          if (int'(mem[((k / OW) * P + y) * W + (k % OW) * P + x]) > exp_max[k])
            exp_max[k] = int'(mem[((k / OW) * P + y) * W + (k % OW) * P + x]);
    end
  endtask
  task automatic check_cycle(input string name, input int c);
    int k, ph;
    logic act, e_rd, e_pe, e_wr;
    k    = (c - 1) / K;
    ph   = (c - 1) % K;
    act  = k < N;
    e_rd = act && ph < P * P;
    e_pe = act && ph >= 1 && ph <= P * P;
    e_wr = act && ph == K - 1;
    chk($sformatf("%s c%0d rd_en", name, c), 32'(bus.rd_en), 32'(e_rd));
    chk($sformatf("%s c%0d pool_en", name, c), 32'(bus.pool_en), 32'(e_pe));
    chk($sformatf("%s c%0d wr_en", name, c), 32'(bus.wr_en), 32'(e_wr));
    chk($sformatf("%s c%0d busy", name, c), 32'(bus.busy), 32'(c <= N * K));
    chk($sformatf("%s c%0d done", name, c), 32'(bus.done), 32'(c == N * K + 1));
    if (e_rd && bus.rd_en)
      chk($sformatf("%s c%0d rd_addr", name, c), 32'(bus.rd_addr),
          32'(((k / OW) * P + ph / P) * W + (k % OW) * P + ph % P));
    if (e_wr && bus.wr_en) begin
      chk($sformatf("%s c%0d wr_addr", name, c), 32'(bus.wr_addr), 32'(k));
      chk($sformatf("%s c%0d wr_data", name, c), 32'(bus.wr_data), 32'(exp_max[k]));
    end
  endtask
  task automatic check_quiet(input string tag);
    chk({tag, " busy"}, 32'(bus.busy), 0);
    chk({tag, " done"}, 32'(bus.done), 0);
    chk({tag, " rd_en"}, 32'(bus.rd_en), 0);
    chk({tag, " pool_en"}, 32'(bus.pool_en), 0);
    chk({tag, " wr_en"}, 32'(bus.wr_en), 0);
  endtask
  task automatic run(input string name, input bit noise, input int busy_start_at);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= N * K + 2; c++) begin
      check_cycle(name, c);
      bus.start = c <= N * K + 1 && (noise ? $urandom_range(0, 1) == 1 : c == busy_start_at);
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (3) begin
      check_quiet({name, " idle"});
      @(negedge clk);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.start = 1'b0;
    load(3);
    for (int c = 0; c < 10; c++) begin
      bus.start = 1'(($urandom));
      @(negedge clk);
      check_quiet("reset");
      chk("reset rd_addr", 32'(bus.rd_addr), 0);
      chk("reset wr_addr", 32'(bus.wr_addr), 0);
      chk("reset wr_data", 32'(bus.wr_data), 0);
    end
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    load(0); run("asc", 1'b0, 0);
    load(1); run("desc", 1'b0, 0);
    load(2); run("pos", 1'b0, 0);
    load(0); run("start_busy", 1'b0, 10);
    for (int r = 0; r < 3; r++) begin
      load(3);
      run($sformatf("rand%0d", r), 1'b1, 0);
    end
    load(3);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c <= 9) check_cycle("midrst", c);
      else begin
        check_quiet($sformatf("midrst c%0d", c));
        chk($sformatf("midrst c%0d wr_data", c), 32'(bus.wr_data), 0);
      end
      if (c == 9) begin
        rst = 1'b0;
        #1;
        check_quiet("midrst async");
        chk("midrst async rd_addr", 32'(bus.rd_addr), 0);
        chk("midrst async wr_addr", 32'(bus.wr_addr), 0);
      end
      if (c == 11) rst = 1'b1;
      @(negedge clk);
    end
    run("after_rst", 1'b0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pool_window_feeder.md
Name: pool_window_feeder

Overview:
- Read-side sequencer for the max-pooling unit.
- Walks an IMG_H x IMG_W feature map held in single-port SRAM, one POOL x POOL window at a time.
- Streams each window's pixels into the pooling unit on its en/Data_in inputs, captures the unit's Data_out after the last pixel, and writes one pooled result per window to an output buffer.
- Sits between the feature-map SRAM and the result SRAM, alongside the pooling unit.

Parameters:
- DATA_BITS, 8, pixel and result width (unsigned).
- IMG_W, 4, feature-map width in pixels; must be a multiple of POOL.
- IMG_H, 4, feature-map height in pixels; must be a multiple of POOL.
- POOL, 2, square window edge; stride equals POOL.
- ADDR_BITS, 8, read and write address width; must cover IMG_W*IMG_H-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- start  input  1  one-cycle request to process the whole map; ignored while busy=1.
- busy  output  1  high from the cycle after start is accepted through the final write.
- done  output  1  one-cycle pulse in the cycle after the final wr_en.
- rd_en  output  1  feature-map SRAM read strobe.
- rd_addr  output  ADDR_BITS  read address, row*IMG_W+col.
- rd_data  input  DATA_BITS  SRAM read data, valid exactly one cycle after rd_en.
- pool_en  output  1  drives the pooling unit's en input.
- pool_data  output  DATA_BITS  drives the pooling unit's Data_in input.
- pool_result  input  DATA_BITS  the pooling unit's Data_out.
- wr_en  output  1  result SRAM write strobe.
- wr_addr  output  ADDR_BITS  result index, out_row*(IMG_W/POOL)+out_col.
- wr_data  output  DATA_BITS  pooled maximum.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; all counters are cleared.
  - busy, done, rd_en, pool_en, wr_en = 0; rd_addr, wr_addr, wr_data = 0.
- pool_data is combinationally equal to rd_data.
- pool_en is rd_en registered by one cycle, so it is high exactly when rd_data is valid.
- FSM states: IDLE, READ, DRAIN, WRITE, FINISH.
- IDLE:
  - start=1 moves to READ and sets busy=1 on the next edge.
  - Window counters (win_r, win_c) are zeroed.
- READ, POOL*POOL consecutive cycles:
  - rd_en=1 every cycle.
  - rd_addr = (win_r*POOL+i)*IMG_W + win_c*POOL + j.
  - i and j run row-major inside the window, with j fastest.
  - After the last element, go to DRAIN.
- DRAIN, 1 cycle:
  - rd_en=0; pool_en=1 for the last pixel of the window.
- WRITE, 1 cycle:
  - pool_en=0; wr_en=1; wr_data=pool_result.
  - wr_addr = win_r*(IMG_W/POOL) + win_c.
  - Because pool_en is low in this cycle, the pooling unit clears to 0 at the end of it, ready for the next window.
  - If more windows remain, advance win_c (wrapping to 0 and incrementing win_r at IMG_W/POOL) and go to READ.
  - Otherwise go to FINISH.
- FINISH, 1 cycle: done=1; busy=0 from this cycle; then go to IDLE.
- Timing:
  - Each window costs POOL*POOL+2 cycles.
  - A full run costs (IMG_H/POOL)*(IMG_W/POOL)*(POOL*POOL+2) cycles between the first rd_en and the final wr_en.
- A gap of at least one cycle with pool_en=0 between windows is mandatory. The unit's maximum starts at 0 and only clears while en is low.
- start during busy has no effect. start in the same cycle as the FINISH pulse is ignored; start is accepted only in IDLE.
- rst asserted mid-run:
  - All activity stops immediately; no further reads or writes are issued.
  - Partial results are not completed. The next start restarts from window 0.
- Pixel values are unsigned; the all-zero window yields 0, which is indistinguishable by design.

Test Plan:
- Reset check: hold rst=0 with random inputs -> busy, done, rd_en, pool_en, wr_en stay 0; addresses and wr_data stay 0.
- Ascending map: 4x4 map with pixel value = address (0..15), start at cycle 0:
  - reads cycles 1-4 use addresses 0,1,4,5.
  - first wr_en at cycle 6 with wr_addr=0, wr_data=5.
  - following writes: (1,7), (2,13), (3,15) at cycles 12, 18, 24.
  - done at cycle 25.
- Descending map: pixel = 15-address -> writes (0,15), (1,13), (2,7), (3,5). Proves the max clears between windows; wr_addr 1 must not report 15.
- Max at different positions: window 0 = {0,0,0,200}, window 1 = {255,0,0,0}, others all 0 -> results 200, 255, 0, 0.
- Start while busy: pulse start again at cycle 10 -> no restart; exactly 4 writes and one done pulse.
- Mid-run reset: rst=0 at cycle 9, release at cycle 11 -> no wr_en after cycle 9. A new start then produces the full correct sequence from wr_addr 0.
